// File: rtl/traffic_pkg.sv
// Shared encodings for the vehicle lights and the pedestrian signal FSM.
package traffic_pkg;

    // Vehicle light encodings, packed as {red, yellow, green}; exactly one lamp lit.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Pedestrian signal state encodings.
    localparam logic [1:0] PED_STOP  = 2'd0;
    localparam logic [1:0] PED_WALK  = 2'd1;
    localparam logic [1:0] PED_FLASH = 2'd2;

    // True when the upstream lights show exactly one legal aspect.
    function automatic logic lights_onehot(input logic [2:0] lights);
        return (lights == LIGHT_RED) || (lights == LIGHT_YELLOW) || (lights == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw push-button followed by a rising-edge
// detector. pulse is high for one cycle per synchronized press.
module btn_sync (
    input  logic clk,
    input  logic rst_an,
    input  logic d,
    output logic pulse
);

    logic s1_q;
    logic s2_q;
    logic dly_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= d;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    // Rising edge of the synchronized button.
    always_comb begin
        pulse = s2_q & ~dly_q;
    end

endmodule

// File: rtl/ped_signal.sv
// Pedestrian crossing signal slaved to an upstream vehicle light controller.
// A latched button press is served at the next rising edge of red; the walk
// and flash phases are timed by a down-counter. Any inconsistency in the
// upstream lights forces the crossing back to STOP and latches a sticky fault.
//
// state | meaning
// ------+-------------------------------------------------------------
// STOP  | dont_walk lit; waiting for red-rise with a pending request
// WALK  | walk lit for WALK_TIME cycles
// FLASH | dont_walk flashing for FLASH_TIME cycles, then back to STOP
module ped_signal
    import traffic_pkg::*;
#(
    parameter int WALK_TIME  = 2,
    parameter int FLASH_TIME = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic             red_d_q;

    logic             press;
    logic             red_rise;
    logic             lights_bad;
    logic             enter_walk;

    btn_sync u_btn_sync (
        .clk    (clk),
        .rst_an (rst_an),
        .d      (ped_btn),
        .pulse  (press)
    );

    // Red delayed by one cycle for red-rise detection.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            red_d_q <= 1'b0;
        end else begin
            red_d_q <= red;
        end
    end

    // Event decode: red-rise and illegal light combinations.
    always_comb begin
        red_rise   = red & ~red_d_q;
        lights_bad = ~lights_onehot({red, yellow, green});
        if ((state_q != PED_STOP) && !red) begin
            // Losing red while pedestrians may be crossing is unsafe.
            lights_bad = 1'b1;
        end
    end

    // Next-state logic for the phase FSM and its down-counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        enter_walk = 1'b0;
        if (lights_bad) begin
            state_d = PED_STOP;
            cnt_d   = CNT_ZERO;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                PED_STOP: begin
                    cnt_d = CNT_ZERO;
                    if (red_rise && req_q && !fault_q) begin
                        state_d    = PED_WALK;
                        cnt_d      = WALK_LOAD;
                        enter_walk = 1'b1;
                    end
                end
                PED_WALK: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = PED_FLASH;
                        cnt_d   = FLASH_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                PED_FLASH: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = PED_STOP;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    // Unused encoding: recover to the safe state.
                    state_d = PED_STOP;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Request latch: cleared when served, presses during WALK are dropped.
    always_comb begin
        req_d = req_q;
        if (enter_walk) begin
            req_d = 1'b0;
        end else if (press && (state_q != PED_WALK)) begin
            req_d = 1'b1;
        end
    end

    // State, counter, request and fault registers.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q <= PED_STOP;
            cnt_q   <= CNT_ZERO;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    // Moore output decode; follows the state register so reset acts at once.
    always_comb begin
        walk        = (state_q == PED_WALK);
        dont_walk   = (state_q != PED_WALK);
        flash       = (state_q == PED_FLASH);
        countdown   = ((state_q == PED_WALK) || (state_q == PED_FLASH)) ? cnt_q : CNT_ZERO;
        req_pending = req_q;
        fault       = fault_q;
    end

endmodule

// File: tb/tb_ped_signal.sv
module tb_ped_signal;

    localparam int WALK_TIME  = 2;
    localparam int FLASH_TIME = 1;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst_an = 1'b0;
    logic             red = 1'b0;
    logic             yellow = 1'b0;
    logic             green = 1'b1;
    logic             ped_btn = 1'b0;
    logic             walk;
    logic             dont_walk;
    logic             flash;
    logic [CNT_W-1:0] countdown;
    logic             req_pending;
    logic             fault;

    int vectors = 0;
    int miscompares = 0;

    // {walk, dont_walk, flash, countdown, req_pending, fault}
    typedef logic [CNT_W+4:0] vec_t;
    vec_t exp_q[$];

    // Reference model state
    int m_st, m_cnt;
    bit m_req, m_fault, m_s1, m_s2, m_d, m_rd;

    ped_signal #(
        .WALK_TIME  (WALK_TIME),
        .FLASH_TIME (FLASH_TIME),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_an      (rst_an),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .flash       (flash),
        .countdown   (countdown),
        .req_pending (req_pending),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard: compare one expected vector per clock edge.
    always @(posedge clk) begin
        vec_t got, want;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {walk, dont_walk, flash, countdown, req_pending, fault};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL scoreboard @%0t: got %b want %b (walk,dw,flash,cd,req,fault)", $time, got, want);
            end
        end
    end

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_req = 0; m_fault = 0;
        m_s1 = 0; m_s2 = 0; m_d = 0; m_rd = 0;
    endtask

    // Advance the model by one edge using the inputs as currently driven.
    task automatic model_step();
        bit press, rr;
        int ones, n_st, n_cnt;
        bit n_req, n_fault, e_walk, e_dw, e_flash;
        int e_cd;
        press = m_s2 & ~m_d;
        rr    = red & ~m_rd;
        ones  = int'(red) + int'(yellow) + int'(green);
        n_st = m_st; n_cnt = m_cnt; n_req = m_req; n_fault = m_fault;
        if (ones != 1 || (m_st != 0 && !red)) begin
            n_st = 0; n_cnt = 0; n_fault = 1;
        end else begin
            case (m_st)
                0: if (rr && m_req && !m_fault) begin n_st = 1; n_cnt = WALK_TIME - 1; end
                1: if (m_cnt == 0) begin n_st = 2; n_cnt = FLASH_TIME - 1; end else n_cnt = m_cnt - 1;
                default: if (m_cnt == 0) begin n_st = 0; n_cnt = 0; end else n_cnt = m_cnt - 1;
            endcase
        end
        if (m_st == 0 && n_st == 1) n_req = 0;
        else if (press && m_st != 1) n_req = 1;
        m_d = m_s2; m_s2 = m_s1; m_s1 = ped_btn; m_rd = red;
        m_st = n_st; m_cnt = n_cnt; m_req = n_req; m_fault = n_fault;
        e_walk  = (m_st == 1);
        e_dw    = (m_st != 1);
        e_flash = (m_st == 2);
        e_cd    = (m_st == 0) ? 0 : m_cnt;
        exp_q.push_back({e_walk, e_dw, e_flash, CNT_W'(e_cd), m_req, m_fault});
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic set_lights(input logic r, input logic y, input logic g);
        red = r; yellow = y; green = g;
    endtask

    task automatic phase(input logic r, input logic y, input logic g, input int n);
        set_lights(r, y, g);
        step(n);
    endtask

    // Press the button for two cycles during green, leaving a pending request.
    task automatic press_in_green();
        set_lights(0, 0, 1);
        ped_btn = 1'b1;
        step(2);
        ped_btn = 1'b0;
        step(2);
    endtask

    task automatic pulse_reset();
        rst_an = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_an = 1'b1;
    endtask

    task automatic test_reset();
        ped_btn = 1'b0;
        set_lights(0, 0, 1);
        rst_an = 1'b0;
        model_reset();
        #2;
        vectors++;
        if (dont_walk !== 1'b1) begin miscompares++; $display("FAIL reset_dont_walk: got %b want 1", dont_walk); end
        vectors++;
        if ({walk, flash, req_pending, fault} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags: got %b want 0000", {walk, flash, req_pending, fault});
        end
        vectors++;
        if (countdown !== '0) begin miscompares++; $display("FAIL reset_countdown: got %0d want 0", countdown); end
        @(negedge clk);
        @(negedge clk);
        rst_an = 1'b1;
    endtask

    task automatic test_full_path();
        phase(0, 0, 1, 2);
        ped_btn = 1'b1;
        step(2);
        vectors++;
        if (req_pending !== 1'b0) begin miscompares++; $display("FAIL req_before_3rd_edge: got %b want 0", req_pending); end
        step(1);
        ped_btn = 1'b0;
        vectors++;
        if (req_pending !== 1'b1) begin miscompares++; $display("FAIL req_at_3rd_edge: got %b want 1", req_pending); end
        phase(0, 0, 1, 2);
        phase(0, 1, 0, 1);
        phase(1, 0, 0, 1);
        vectors++;
        if ({walk, countdown} !== {1'b1, CNT_W'(1)}) begin
            miscompares++; $display("FAIL walk_k1: got walk=%b cd=%0d want walk=1 cd=1", walk, countdown);
        end
        vectors++;
        if (req_pending !== 1'b0) begin miscompares++; $display("FAIL req_clear_on_walk: got %b want 0", req_pending); end
        step(1);
        vectors++;
        if ({walk, countdown} !== {1'b1, CNT_W'(0)}) begin
            miscompares++; $display("FAIL walk_k2: got walk=%b cd=%0d want walk=1 cd=0", walk, countdown);
        end
        step(1);
        vectors++;
        if ({walk, dont_walk, flash} !== 3'b011) begin
            miscompares++; $display("FAIL flash_k3: got %b want 011", {walk, dont_walk, flash});
        end
        step(1);
        vectors++;
        if ({walk, dont_walk, flash, red} !== 4'b0101) begin
            miscompares++; $display("FAIL stop_k4: got %b want 0101 (walk,dw,flash,red)", {walk, dont_walk, flash, red});
        end
        step(1);
        phase(0, 0, 1, 2);
    endtask

    task automatic test_no_press();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 10; i++) begin
                if (i < 4) set_lights(0, 0, 1);
                else if (i < 5) set_lights(0, 1, 0);
                else set_lights(1, 0, 0);
                step(1);
                vectors++;
                if (walk !== 1'b0 || dont_walk !== 1'b1) begin
                    miscompares++; $display("FAIL no_press_idle: cycle %0d.%0d got walk=%b dw=%b want 0 1", c, i, walk, dont_walk);
                end
            end
        end
        set_lights(0, 0, 1);
    endtask

    task automatic test_press_in_phases();
        // Press detected in WALK is dropped.
        press_in_green();
        phase(0, 1, 0, 1);
        set_lights(1, 0, 0);
        ped_btn = 1'b1;
        step(2);
        ped_btn = 1'b0;
        step(1);
        vectors++;
        if (req_pending !== 1'b0) begin miscompares++; $display("FAIL press_in_walk: got req=%b want 0", req_pending); end
        step(2);
        vectors++;
        if (req_pending !== 1'b0) begin miscompares++; $display("FAIL press_in_walk_late: got req=%b want 0", req_pending); end
        // Press detected in FLASH is latched and served next red-rise.
        press_in_green();
        phase(0, 1, 0, 1);
        phase(1, 0, 0, 1);
        ped_btn = 1'b1;
        step(2);
        ped_btn = 1'b0;
        step(1);
        vectors++;
        if ({req_pending, walk} !== 2'b10) begin
            miscompares++; $display("FAIL press_in_flash: got req,walk=%b want 10", {req_pending, walk});
        end
        step(1);
        phase(0, 0, 1, 4);
        phase(0, 1, 0, 1);
        phase(1, 0, 0, 1);
        vectors++;
        if (walk !== 1'b1) begin miscompares++; $display("FAIL flash_press_served: got walk=%b want 1", walk); end
        // Press during red while in STOP waits for the next red.
        step(1);
        ped_btn = 1'b1;
        step(2);
        ped_btn = 1'b0;
        step(1);
        vectors++;
        if ({req_pending, walk} !== 2'b10) begin
            miscompares++; $display("FAIL press_in_red_stop: got req,walk=%b want 10", {req_pending, walk});
        end
        phase(0, 0, 1, 4);
        phase(0, 1, 0, 1);
        phase(1, 0, 0, 1);
        vectors++;
        if (walk !== 1'b1) begin miscompares++; $display("FAIL red_press_served: got walk=%b want 1", walk); end
        step(4);
        phase(0, 0, 1, 2);
    endtask

    task automatic test_fault_red_drop();
        int bad;
        press_in_green();
        phase(0, 1, 0, 1);
        phase(1, 0, 0, 1);
        set_lights(0, 0, 1);
        step(1);
        vectors++;
        if ({fault, walk, dont_walk} !== 3'b101) begin
            miscompares++; $display("FAIL red_drop_fault: got fault,walk,dw=%b want 101", {fault, walk, dont_walk});
        end
        bad = 0;
        for (int c = 0; c < 2; c++) begin
            press_in_green();
            phase(0, 1, 0, 1);
            for (int i = 0; i < 5; i++) begin
                phase(1, 0, 0, 1);
                if (walk !== 1'b0) bad++;
            end
        end
        vectors++;
        if (bad != 0 || fault !== 1'b1 || req_pending !== 1'b1) begin
            miscompares++; $display("FAIL fault_blocks_walk: walk cycles=%0d fault=%b req=%b want 0 1 1", bad, fault, req_pending);
        end
        set_lights(0, 0, 1);
        pulse_reset();
        vectors++;
        if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_cleared_by_reset: got %b want 0", fault); end
        step(2);
    endtask

    task automatic test_onehot_and_async_reset();
        set_lights(1, 0, 1);
        step(1);
        vectors++;
        if (fault !== 1'b1) begin miscompares++; $display("FAIL not_onehot_fault: got %b want 1", fault); end
        set_lights(0, 0, 1);
        pulse_reset();
        press_in_green();
        phase(0, 1, 0, 1);
        phase(1, 0, 0, 1);
        vectors++;
        if (walk !== 1'b1) begin miscompares++; $display("FAIL walk_before_reset: got %b want 1", walk); end
        #1;
        rst_an = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        vectors++;
        if ({walk, dont_walk, countdown} !== {2'b01, CNT_W'(0)}) begin
            miscompares++; $display("FAIL async_reset_walk: got walk=%b dw=%b cd=%0d want 0 1 0", walk, dont_walk, countdown);
        end
        @(negedge clk);
        set_lights(0, 0, 1);
        rst_an = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_full_path();
        test_no_press();
        test_press_in_phases();
        test_fault_red_drop();
        test_onehot_and_async_reset();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected vectors never compared", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
